systolic_array_input_skewer: RTL
================================

# systolic_array_input_skewer

Upstream feeder for a systolic array row edge. It accepts one vector of `num_rows` elements per handshake and drives each row's `x_in` with the staggered (diagonal) timing the array needs: row i is delayed i cycles more than row 0. After the final vector it flushes zeros so every row drains, then pulses `done`. The block is free-running like the array, and non-accepted cycles inject zero bubbles.

## Interface
- `data_width`, 32, width of one element
- `num_rows`, 4, number of array rows fed; must be ≥ 2
- `clk`  input  1  clock, all state on rising edge
- `reset`  input  1  asynchronous, active-high; all state cleared immediately
- `in_val`  input  1  input vector valid
- `in_rdy`  output  1  block can accept a vector this cycle
- `in_last`  input  1  accepted vector is the last of the stream; sampled only on handshake
- `in_data`  input  num_rows*data_width  row i element at bits `[i*data_width +: data_width]`
- `out_x`  output  num_rows*data_width  per-row element to array `x_in`, same packing
- `out_val`  output  num_rows  per-row element valid (bubble = 0)
- `busy`  output  1  state ≠ IDLE
- `done`  output  1  one-cycle pulse when row num_rows-1 emits the last element

## Operation
- Handshake: a vector is accepted on a rising edge where `in_val && in_rdy`.
- `in_rdy = (state != FLUSH)`, decoded combinationally from state.
- Each row i has a delay line of depth i+1 that carries {valid, data}. All delay lines shift every cycle without stalling.
- On accept, row i's delay line loads {1, element i}. Otherwise it loads {0, 0}, so bubbles are zero-valued and a MAC is unaffected.
- `out_x` row = 0 whenever its `out_val` = 0. This is guaranteed by the loaded value, not by masking.
- FSM states:
  - IDLE → STREAM on accept with `in_last` = 0.
  - IDLE → FLUSH on accept with `in_last` = 1 (single-vector stream).
  - STREAM → FLUSH on accept with `in_last` = 1. STREAM otherwise holds, and gaps in `in_val` are allowed.
  - FLUSH: counter loads `num_rows-1` on entry and decrements every cycle. At 0, `done` asserts and the next state is IDLE.
- `in_val` asserted during FLUSH is ignored: no accept, and the data is not consumed.
- Counter width is `$clog2(num_rows)`. It never wraps because it is only decremented in FLUSH while nonzero.
- Reset mid-stream or mid-flush: all delay lines go to {0,0}, the state goes to IDLE, the counter goes to 0, and no `done` is produced. In-flight elements are discarded.

## Timing
- Reset values: `out_x` = 0, `out_val` = 0, `busy` = 0, `done` = 0, `in_rdy` = 1 (IDLE).
- For a vector accepted at edge t, row i's element is visible on `out_x` and `out_val` during the cycle after edge t+i, so latency is i+1 cycles.
- For a last vector accepted at edge t, FLUSH spans the cycles after edges t … t+num_rows-1. `done` is high in the same cycle that row num_rows-1 shows the last element. `in_rdy` returns to 1 in the following cycle.
- Back-to-back accepts, one per cycle, produce continuous `out_val` = 1 on every row, offset diagonally.
- `busy` = 1 from the cycle after the first accept through the `done` cycle inclusive.

## Structure
- Shared package `systolic_array_pkg`:
  - FSM state enum {IDLE, STREAM, FLUSH}.
  - Helper constant for the counter width.
- Sub-module `systolic_array_DelayLine` holds {valid, data} with parameters `data_width` and `depth` (≥ 1) and an async-reset register chain. The skewer instantiates it once per row via generate, with depth = i+1.
- Top level holds the FSM, the flush counter, handshake logic and slice packing.

## Test plan
- Reset release with no input (`num_rows`=4): all outputs hold reset values for 10 cycles and `in_rdy` = 1.
- Single vector {row0..3 = 1,2,3,4} with `in_last`=1 accepted at edge 0: row0=1 in cycle 1, row1=2 in cycle 2, row2=3 in cycle 3, row3=4 in cycle 4 with `done`=1. `in_rdy`=0 in cycles 1–4 and `in_rdy`=1 in cycle 5.
- Three back-to-back vectors (0x10+i, 0x20+i, 0x30+i), last on the third: each row shows 3 consecutive valid cycles, row3 shows 0x13, 0x23, 0x33 in cycles 4–6, and `done` occurs in cycle 6.
- Vector, 2-cycle `in_val` gap, then last vector: each row's output shows a 2-cycle bubble (`out_val`=0, `out_x`=0) between the elements, with the correct diagonal offset.
- `in_val`=1 held during FLUSH with data 0xDEAD: no accept, 0xDEAD never appears on `out_x`, and the vector is accepted in the first cycle `in_rdy` = 1.
- Reset asserted asynchronously mid-FLUSH, between edges: outputs go to zero immediately, and no `done` follows after release.

Source files
------------

// File: rtl/systolic_array_input_skewer_pkg.sv
// rtl/systolic_array_input_skewer_pkg.sv - shared FSM states and sizing helpers for the input skewer
package systolic_array_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        FLUSH  = 2'd2
    } state_t;

    // Width of the flush counter; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/systolic_array_input_skewer_if.sv
// rtl/systolic_array_input_skewer_if.sv - vector input handshake and per-row array feed bundle
interface systolic_array_input_skewer_if #(
    parameter int data_width = 32,
    parameter int num_rows   = 4
);
    logic                           in_val;
    logic                           in_rdy;
    logic                           in_last;
    logic [num_rows*data_width-1:0] in_data;
    logic [num_rows*data_width-1:0] out_x;
    logic [num_rows-1:0]            out_val;
    logic                           busy;
    logic                           done;

    modport master (
        output in_val, in_last, in_data,
        input  in_rdy, out_x, out_val, busy, done
    );

    modport slave (
        input  in_val, in_last, in_data,
        output in_rdy, out_x, out_val, busy, done
    );
endinterface

// File: rtl/systolic_array_input_skewer_delay_line.sv
// rtl/systolic_array_input_skewer_delay_line.sv - fixed-depth {valid, data} shift register
module systolic_array_DelayLine #(
    parameter int data_width = 32,
    parameter int depth      = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_valid,
    input  logic [data_width-1:0] i_data,
    output logic                  o_valid,
    output logic [data_width-1:0] o_data
);
    logic [depth-1:0]      r_valid;
    logic [data_width-1:0] r_data [depth];

    // Shift every cycle, no stall; reset empties the whole chain at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid <= '0;
            for (int k = 0; k < depth; k++) r_data[k] <= '0;
        end else begin
            r_valid[0] <= i_valid;
            r_data[0]  <= i_data;
            for (int k = 1; k < depth; k++) begin
                r_valid[k] <= r_valid[k-1];
                r_data[k]  <= r_data[k-1];
            end
        end
    end

    assign o_valid = r_valid[depth-1];
    assign o_data  = r_data[depth-1];
endmodule

// File: rtl/systolic_array_input_skewer.sv
// rtl/systolic_array_input_skewer.sv - diagonal skew feeder for a systolic array row edge
module systolic_array_input_skewer
    import systolic_array_pkg::*;
#(
    parameter int data_width = 32,
    parameter int num_rows   = 4
) (
    input  logic clk,
    input  logic reset,
    systolic_array_input_skewer_if.slave s
);
    localparam int CW = cnt_width(num_rows);

    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic          r_done;
    logic          w_accept;

    assign s.in_rdy = (r_state != FLUSH);
    assign w_accept = s.in_val && s.in_rdy;
    assign s.busy   = (r_state != IDLE);
    assign s.done   = r_done;

    // Stream/flush sequencing; done is registered so it lines up with the last row's final element.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                FLUSH: begin
                    if (r_cnt == '0) begin
                        r_state <= IDLE;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                        if (r_cnt == CW'(1)) r_done <= 1'b1;
                    end
                end
                default: begin
                    if (w_accept) begin
                        if (s.in_last) begin
                            r_state <= FLUSH;
                            r_cnt   <= CW'(num_rows - 1);
                        end else begin
                            r_state <= STREAM;
                        end
                    end
                end
            endcase
        end
    end

    // Row i gets a delay of i+1; non-accepted cycles load a zero bubble.
    for (genvar i = 0; i < num_rows; i++) begin : g_row
        logic [data_width-1:0] w_elem;
        assign w_elem = w_accept ? s.in_data[i*data_width +: data_width] : '0;

        systolic_array_DelayLine #(
            .data_width (data_width),
            .depth      (i + 1)
        ) u_line (
            .clk     (clk),
            .reset   (reset),
            .i_valid (w_accept),
            .i_data  (w_elem),
            .o_valid (s.out_val[i]),
            .o_data  (s.out_x[i*data_width +: data_width])
        );
    end
endmodule
